fai_cfg_master: RTL

Initiator side of the FOFB communication-controller configuration port (address, write data, write enable, read data). It turns a simple valid/ready request stream from PCIe-side control logic into single-word config-space writes and fixed-latency reads, and returns read data on a one-cycle response strobe. An optional background poller periodically refreshes a shadow of a status window. It sits on the controller side, in the configuration clock domain.

---
 rtl/fai_cfg_pkg.sv | 18 +
 rtl/fai_cfg_master_if.sv | 34 +++
 rtl/fai_cfg_master.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fai_cfg_pkg.sv
// Shared definitions for the FOFB configuration-port initiator: widths,
// the write-acknowledge data word and the FSM state encoding.
package fai_cfg_pkg;

  localparam int FAI_CFG_AW = 11;
  localparam int FAI_CFG_DW = 32;

  localparam logic [FAI_CFG_DW-1:0] FAI_CFG_WR_ACK = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR        = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_RESP      = 3'd3,
    ST_POLL_WAIT = 3'd4
  } fai_cfg_state_e;

endpackage

// File: rtl/fai_cfg_master_if.sv
// Host-side request/response stream of the configuration-port initiator.
// The master modport is the requester; the slave modport is fai_cfg_master.
interface fai_cfg_master_if;
  import fai_cfg_pkg::*;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [FAI_CFG_AW-1:0] req_addr_i;
  logic [FAI_CFG_DW-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic [FAI_CFG_DW-1:0] rsp_rdata_o;

  modport master (
    output req_valid_i,
    output req_we_i,
    output req_addr_i,
    output req_wdata_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_rdata_o
  );

  modport slave (
    input  req_valid_i,
    input  req_we_i,
    input  req_addr_i,
    input  req_wdata_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_rdata_o
  );

endinterface

// File: rtl/fai_cfg_master.sv
// Config-port initiator: valid/ready requests become single-word writes or
// fixed-latency reads. Define FAI_CFG_POLL_EN to add the status-window poller.
module fai_cfg_master
  import fai_cfg_pkg::*;
#(
  parameter int                  RD_LATENCY  = 2,
  parameter logic [FAI_CFG_AW-1:0] POLL_BASE = 11'h000,
  parameter int                  POLL_COUNT  = 8,
  parameter logic [15:0]         POLL_PERIOD = 16'd1000
) (
  input  logic                  clk,
  input  logic                  rst,
  fai_cfg_master_if.slave       bus,
  output logic [FAI_CFG_AW-1:0] fai_cfg_a_o,
  output logic [FAI_CFG_DW-1:0] fai_cfg_do_o,
  output logic                  fai_cfg_we_o,
  input  logic [FAI_CFG_DW-1:0] fai_cfg_di_i,
  output logic [FAI_CFG_DW-1:0] poll_dat_o,
  output logic [3:0]            poll_idx_o,
  output logic                  poll_valid_o,
  output logic                  busy_o
);

  fai_cfg_state_e        state_q, state_d;
  logic [FAI_CFG_AW-1:0] addr_q;
  logic [FAI_CFG_DW-1:0] wdata_q;
  logic [FAI_CFG_DW-1:0] rdata_q;
  logic [2:0]            lat_q;
  logic                  lat_done;
  logic                  host_take;
  logic                  poll_start;
  logic [FAI_CFG_AW-1:0] poll_addr;

  // The count completes on the cycle the read data is valid on the port.
  assign lat_done  = (lat_q == 3'(RD_LATENCY - 1));
  assign host_take = (state_q == ST_IDLE) && bus.req_valid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.req_ready_o  = 1'b0;
    bus.rsp_valid_o  = 1'b0;
    fai_cfg_we_o     = 1'b0;
    busy_o           = 1'b1;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready_o = ~rst;
        busy_o          = 1'b0;
        if (bus.req_valid_i) begin
          state_d = bus.req_we_i ? ST_WR : ST_RD_WAIT;
        end else if (poll_start) begin
          state_d = ST_POLL_WAIT;
        end
      end
      ST_WR: begin
        fai_cfg_we_o = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RD_WAIT: begin
        if (lat_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid_o = 1'b1;
        state_d         = ST_IDLE;
      end
      ST_POLL_WAIT: begin
        if (lat_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
    end else begin
      if (host_take) begin
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
      end else if (poll_start) begin
        addr_q  <= poll_addr;
      end

      if (state_q == ST_IDLE) begin
        lat_q <= '0;
      end else if ((state_q == ST_RD_WAIT || state_q == ST_POLL_WAIT) && !lat_done) begin
        lat_q <= lat_q + 3'd1;
      end

      if (state_q == ST_WR) begin
        rdata_q <= FAI_CFG_WR_ACK;
      end else if (state_q == ST_RD_WAIT && lat_done) begin
        rdata_q <= fai_cfg_di_i;
      end
    end
  end

  assign fai_cfg_a_o     = addr_q;
  assign fai_cfg_do_o    = wdata_q;
  assign bus.rsp_rdata_o = rdata_q;

`ifdef FAI_CFG_POLL_EN
  logic [15:0]           period_q;
  logic                  pending_q;
  logic [3:0]            idx_q;
  logic [FAI_CFG_DW-1:0] pdat_q;
  logic [3:0]            pidx_q;
  logic                  pvld_q;
  logic                  period_wrap;
  logic                  word_done;
  logic                  sweep_end;

  assign period_wrap = (period_q == POLL_PERIOD - 16'd1);
  assign word_done   = (state_q == ST_POLL_WAIT) && lat_done;
  assign sweep_end   = word_done && (idx_q == 4'(POLL_COUNT - 1));
  // Host requests always win; a sweep only advances from IDLE with no request.
  assign poll_start  = (state_q == ST_IDLE) && pending_q && !bus.req_valid_i;
  assign poll_addr   = POLL_BASE + FAI_CFG_AW'(idx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q  <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      pdat_q    <= '0;
      pidx_q    <= '0;
      pvld_q    <= 1'b0;
    end else begin
      period_q <= period_wrap ? 16'd0 : period_q + 16'd1;
      // A wrap landing on a still-pending sweep is simply absorbed.
      if (sweep_end) begin
        pending_q <= 1'b0;
      end else if (period_wrap) begin
        pending_q <= 1'b1;
      end
      pvld_q <= word_done;
      if (word_done) begin
        pdat_q <= fai_cfg_di_i;
        pidx_q <= idx_q;
        idx_q  <= sweep_end ? 4'd0 : idx_q + 4'd1;
      end
    end
  end

  assign poll_dat_o   = pdat_q;
  assign poll_idx_o   = pidx_q;
  assign poll_valid_o = pvld_q;
`else
  logic unused_poll_cfg;

  assign poll_start      = 1'b0;
  assign poll_addr       = '0;
  assign poll_dat_o      = '0;
  assign poll_idx_o      = '0;
  assign poll_valid_o    = 1'b0;
  assign unused_poll_cfg = ^{POLL_BASE, POLL_PERIOD, 5'(POLL_COUNT)};
`endif

endmodule
